// File: rtl/ghost_crash_scheduler_if.sv
// Scan request/result bundle between the sprite registers,
// the collision scheduler and the game-state FSM.
`timescale 1ns/1ps
interface ghost_crash_scheduler_if #(
  parameter int NUM_GHOSTS = 4,
  parameter int IDW        = 2
);
  logic                    start;
  logic [9:0]              pac_x;
  logic [8:0]              pac_y;
  logic [10*NUM_GHOSTS-1:0] ghost_x;
  logic [9*NUM_GHOSTS-1:0]  ghost_y;
  logic [NUM_GHOSTS-1:0]   ghost_en;
  logic                    busy;
  logic                    done;
  logic [NUM_GHOSTS-1:0]   hit_vec;
  logic                    crash;
  logic [IDW-1:0]          hit_id;

  modport master (
    output start, pac_x, pac_y,
    output ghost_x, ghost_y, ghost_en,
    input  busy, done, hit_vec,
    input  crash, hit_id
  );

  modport slave (
    input  start, pac_x, pac_y,
    input  ghost_x, ghost_y, ghost_en,
    output busy, done, hit_vec,
    output crash, hit_id
  );
endinterface

// File: rtl/ghost_crash_scheduler.sv
// Pac-Man/ghost collision checker: snapshots positions and
// scans ghosts through one shared squaring multiplier.
`timescale 1ns/1ps
module ghost_crash_scheduler #(
  parameter int NUM_GHOSTS = 4,
  parameter int RADIUS_SQ  = 2048,
  parameter int IDW        = 2
) (
  input  logic clk,
  input  logic rst,
  ghost_crash_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, SQX, SQY, CMP, DONE
  } state_t;

  localparam logic [31:0] RSQ = RADIUS_SQ;
  localparam logic [IDW-1:0] LAST =
    IDW'(NUM_GHOSTS - 1);

  state_t                  state_q, state_d;
  logic [IDW-1:0]          idx_q, idx_d;
  logic [20:0]             acc_q, acc_d;
  logic [NUM_GHOSTS-1:0]   hits_q, hits_d;
  logic [9:0]              px_q, px_d;
  logic [8:0]              py_q, py_d;
  logic [10*NUM_GHOSTS-1:0] gx_q, gx_d;
  logic [9*NUM_GHOSTS-1:0]  gy_q, gy_d;
  logic [NUM_GHOSTS-1:0]   en_q, en_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [NUM_GHOSTS-1:0]   hit_vec_q, hit_vec_d;
  logic                    crash_q, crash_d;
  logic [IDW-1:0]          hit_id_q, hit_id_d;

  logic [9:0]  gx_sel;
  logic [8:0]  gy_sel;
  logic [9:0]  dx;
  logic [8:0]  dy;
  logic [9:0]  opnd;
  logic [19:0] prod;
  logic [IDW-1:0] low_id;

  assign gx_sel = gx_q[idx_q*10 +: 10];
  assign gy_sel = gy_q[idx_q*9 +: 9];

  // Compare before subtracting so the difference never wraps.
  assign dx = (px_q >= gx_sel) ? px_q - gx_sel
                               : gx_sel - px_q;
  assign dy = (py_q >= gy_sel) ? py_q - gy_sel
                               : gy_sel - py_q;

  assign opnd = (state_q == SQY) ? {1'b0, dy} : dx;
  assign prod = {10'b0, opnd} * {10'b0, opnd};

  always_comb begin
    low_id = '0;
    for (int i = NUM_GHOSTS - 1; i >= 0; i--) begin
      if (hits_q[i]) low_id = IDW'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    hits_d    = hits_q;
    px_d      = px_q;
    py_d      = py_q;
    gx_d      = gx_q;
    gy_d      = gy_q;
    en_d      = en_q;
    hit_vec_d = hit_vec_q;
    crash_d   = crash_q;
    hit_id_d  = hit_id_q;
    busy_d    = (state_q == SQX) ||
                (state_q == SQY) ||
                (state_q == CMP);
    done_d    = (state_q == DONE);
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          px_d    = bus.pac_x;
          py_d    = bus.pac_y;
          gx_d    = bus.ghost_x;
          gy_d    = bus.ghost_y;
          en_d    = bus.ghost_en;
          idx_d   = '0;
          hits_d  = '0;
          state_d = SQX;
        end
      end
      SQX: begin
        acc_d   = {1'b0, prod};
        state_d = SQY;
      end
      SQY: begin
        acc_d   = acc_q + {1'b0, prod};
        state_d = CMP;
      end
      CMP: begin
        hits_d[idx_q] = (32'(acc_q) < RSQ) &&
                        en_q[idx_q];
        if (idx_q == LAST) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDW'(1);
          state_d = SQX;
        end
      end
      DONE: begin
        hit_vec_d = hits_q;
        crash_d   = |hits_q;
        hit_id_d  = low_id;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      hits_q    <= '0;
      px_q      <= '0;
      py_q      <= '0;
      gx_q      <= '0;
      gy_q      <= '0;
      en_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hit_vec_q <= '0;
      crash_q   <= 1'b0;
      hit_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      hits_q    <= hits_d;
      px_q      <= px_d;
      py_q      <= py_d;
      gx_q      <= gx_d;
      gy_q      <= gy_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hit_vec_q <= hit_vec_d;
      crash_q   <= crash_d;
      hit_id_q  <= hit_id_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.hit_vec = hit_vec_q;
  assign bus.crash   = crash_q;
  assign bus.hit_id  = hit_id_q;

endmodule

// File: tb/tb_ghost_crash_scheduler.sv
// Bench for ghost_crash_scheduler: vector table, scoreboard
// on done, and hand-written latency/snapshot/reset sequences.
`timescale 1ns/1ps
module tb_ghost_crash_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ghost_crash_scheduler_if #(
    .NUM_GHOSTS(4), .IDW(2)
  ) bus ();

  ghost_crash_scheduler #(
    .NUM_GHOSTS(4), .RADIUS_SQ(2048), .IDW(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [9:0]  px;
    logic [8:0]  py;
    logic [39:0] gx;
    logic [35:0] gy;
    logic [3:0]  en;
    logic [3:0]  hv;
    logic [1:0]  id;
  } vec_t;

  typedef struct {
    logic [3:0] hv;
    logic       cr;
    logic [1:0] id;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[9];
  int   n_chk  = 0;
  int   n_fail = 0;

  localparam logic [9:0] FX = 10'd600;
  localparam logic [8:0] FY = 9'd400;

  function automatic logic [39:0] xs(
    input logic [9:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [35:0] ys(
    input logic [8:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] hv,
                      input logic [1:0] id);
    exp_t e;
    e.hv = hv;
    e.cr = |hv;
    e.id = id;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.done) begin
      chk("done_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("hit_vec", 32'(bus.hit_vec), 32'(e.hv));
        chk("crash",   32'(bus.crash),   32'(e.cr));
        chk("hit_id",  32'(bus.hit_id),  32'(e.id));
      end
    end
  endtask

  task automatic apply(input vec_t v);
    bus.pac_x    = v.px;
    bus.pac_y    = v.py;
    bus.ghost_x  = v.gx;
    bus.ghost_y  = v.gy;
    bus.ghost_en = v.en;
  endtask

  task automatic pulse();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_empty(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk({nm, "_timeout"}, 32'(sb.size()), 0);
    sb.delete();
    tick();
  endtask

  initial begin
    vec_t v;
    int   bcnt;

    tbl[0] = '{10'd100, 9'd100,
      xs(10'd145, FX, FX, FX), ys(9'd100, FY, FY, FY),
      4'b1111, 4'b0001, 2'd0};
    tbl[1] = '{10'd100, 9'd100,
      xs(10'd146, FX, FX, FX), ys(9'd100, FY, FY, FY),
      4'b1111, 4'b0000, 2'd0};
    tbl[2] = '{10'd100, 9'd100,
      xs(10'd132, FX, FX, FX), ys(9'd132, FY, FY, FY),
      4'b1111, 4'b0000, 2'd0};
    tbl[3] = '{10'd5, 9'd100,
      xs(10'd1020, FX, FX, FX), ys(9'd100, FY, FY, FY),
      4'b1111, 4'b0000, 2'd0};
    tbl[4] = '{10'd100, 9'd100,
      xs(FX, 10'd100, FX, 10'd100),
      ys(FY, 9'd100, FY, 9'd100),
      4'b1101, 4'b1000, 2'd3};
    tbl[5] = '{10'd100, 9'd100,
      xs(FX, 10'd100, FX, 10'd100),
      ys(FY, 9'd100, FY, 9'd100),
      4'b1111, 4'b1010, 2'd1};
    tbl[6] = '{10'd100, 9'd100,
      xs(FX, FX, 10'd131, FX), ys(FY, FY, 9'd131, FY),
      4'b1111, 4'b0100, 2'd2};
    tbl[7] = '{10'd100, 9'd100,
      xs(10'd100, 10'd100, 10'd100, 10'd100),
      ys(9'd100, 9'd100, 9'd100, 9'd100),
      4'b0000, 4'b0000, 2'd0};
    tbl[8] = '{10'd0, 9'd0,
      xs(10'd1023, FX, FX, 10'd1), ys(9'd511, FY, FY, 9'd1),
      4'b1111, 4'b1000, 2'd3};

    bus.start = 1'b0;
    apply(tbl[0]);
    tick();
    tick();
    chk("rst_busy",    32'(bus.busy), 0);
    chk("rst_done",    32'(bus.done), 0);
    chk("rst_hit_vec", 32'(bus.hit_vec), 0);
    chk("rst_crash",   32'(bus.crash), 0);
    chk("rst_hit_id",  32'(bus.hit_id), 0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      apply(tbl[i]);
      push(tbl[i].hv, tbl[i].id);
      pulse();
      wait_empty($sformatf("vec%0d", i));
    end

    // Latency, busy length, ignored starts.
    apply(tbl[0]);
    push(4'b0001, 2'd0);
    pulse();
    bcnt = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (bus.busy) bcnt++;
      chk($sformatf("lat_busy_k%0d", k),
          32'(bus.busy), 32'(k <= 12));
      chk($sformatf("lat_done_k%0d", k),
          32'(bus.done), 32'(k == 13));
      if (k == 4 || k == 12) bus.start = 1'b1;
      if (k == 5 || k == 13) bus.start = 1'b0;
    end
    chk("busy_cycles", 32'(bcnt), 12);
    chk("lat_sb_empty", 32'(sb.size()), 0);
    sb.delete();

    // Snapshot: inputs change mid-scan.
    v = '{10'd100, 9'd100,
      xs(FX, FX, FX, FX), ys(FY, FY, FY, FY),
      4'b1111, 4'b0000, 2'd0};
    apply(v);
    push(4'b0000, 2'd0);
    pulse();
    repeat (3) tick();
    bus.ghost_x = xs(10'd100, FX, 10'd100, FX);
    bus.ghost_y = ys(9'd100, FY, 9'd100, FY);
    wait_empty("snap_first");
    push(4'b0101, 2'd0);
    pulse();
    wait_empty("snap_second");

    // Reset mid-scan.
    v = '{10'd100, 9'd100,
      xs(FX, 10'd100, FX, FX), ys(FY, 9'd100, FY, FY),
      4'b1111, 4'b0010, 2'd1};
    apply(v);
    push(4'b0010, 2'd1);
    pulse();
    wait_empty("pre_rst");
    chk("pre_rst_hit_vec", 32'(bus.hit_vec), 32'h2);
    push(4'b0010, 2'd1);
    pulse();
    repeat (5) tick();
    #2;
    rst = 1'b0;
    #1;
    chk("mrst_busy",    32'(bus.busy), 0);
    chk("mrst_done",    32'(bus.done), 0);
    chk("mrst_hit_vec", 32'(bus.hit_vec), 0);
    chk("mrst_crash",   32'(bus.crash), 0);
    chk("mrst_hit_id",  32'(bus.hit_id), 0);
    sb.delete();
    repeat (3) tick();
    rst = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("post_rst_busy", 32'(bus.busy), 0);
      chk("post_rst_done", 32'(bus.done), 0);
    end
    push(4'b0010, 2'd1);
    pulse();
    wait_empty("post_rst_scan");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
